icache_nway_wide_lru: RTL and testbench

// Parametrised N-way set-associative instruction cache. Refills a whole line per memory transaction and returns one word to the core.

---
 rtl/icache_nway_wide_lru.sv | 198 +++++++++++++++++++
 tb/tb_icache_nway_wide_lru.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway_wide_lru.sv
// N-way set-associative instruction cache: whole-line refill, one word to the core,
// LRU or round-robin victim choice, full-cache flush and saturating hit/miss counters.
module icache_nway_wide_lru #(
    parameter int CACHE_SIZE  = 1024,
    parameter int NUM_WAYS    = 2,
    parameter int NUM_BLOCKS  = 4,
    parameter int BLOCK_SIZE  = 4,
    parameter int REPL_POLICY = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               proc_valid,
    output logic                               proc_ready,
    input  logic [31:0]                        proc_addr,
    output logic [8*BLOCK_SIZE-1:0]            proc_rdata,
    input  logic                               flush,
    output logic                               flush_busy,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [31:0]                        mem_req_addr,
    input  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0] mem_req_rdata,
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count
);
    localparam int WORD_BITS = 8 * BLOCK_SIZE;
    localparam int LINE_BITS = WORD_BITS * NUM_BLOCKS;
    localparam int NUM_SETS  = CACHE_SIZE / (NUM_BLOCKS * BLOCK_SIZE * NUM_WAYS);
    localparam int OFF_W     = $clog2(BLOCK_SIZE);
    localparam int WOFF_W    = $clog2(NUM_BLOCKS);
    localparam int IDX_W     = $clog2(NUM_SETS);
    localparam int LINE_OFF  = OFF_W + WOFF_W;
    localparam int TAG_W     = 32 - LINE_OFF - IDX_W;
    localparam int AGE_W     = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_FLUSH} state_t;

    state_t              state_reg;
    logic [31:0]         addr_reg;
    logic                flush_pend_reg;
    logic [IDX_W-1:0]    flush_set_reg;
    logic [NUM_WAYS-1:0] valid_reg [NUM_SETS];
    logic [AGE_W-1:0]    age_reg   [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]    rr_reg    [NUM_SETS];

    logic [TAG_W-1:0]     tag_mem  [NUM_WAYS][NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_WAYS][NUM_SETS];

    // Lookup uses the live request in IDLE and the latched miss address while refilling.
    logic [31:0]       lk_addr;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  lk_idx;
    logic [WOFF_W-1:0] lk_woff;
    logic              unused_bits;

    assign lk_addr     = (state_reg == ST_MISS) ? addr_reg : proc_addr;
    assign lk_tag      = lk_addr[31 -: TAG_W];
    assign lk_idx      = lk_addr[LINE_OFF +: IDX_W];
    assign lk_woff     = lk_addr[OFF_W +: WOFF_W];
    assign unused_bits = ^lk_addr[OFF_W-1:0];

    logic [NUM_WAYS-1:0] way_hit;
    logic                hit_any;
    logic [AGE_W-1:0]    hit_way;
    logic [AGE_W-1:0]    victim;
    logic [AGE_W-1:0]    upd_way;
    logic [AGE_W-1:0]    upd_age;
    logic [AGE_W-1:0]    age_next [NUM_WAYS];
    logic [LINE_BITS-1:0] hit_line;
    logic [WORD_BITS-1:0] hit_word;
    logic [WORD_BITS-1:0] fill_word;
    logic                 fill_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[lk_idx][gi] && (tag_mem[gi][lk_idx] == lk_tag);
        end
    endgenerate

    assign hit_any = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_way = AGE_W'(w);
        end
    end

    // Policy choice first, then the lowest-index invalid way overrides it.
    always_comb begin
        victim = '0;
        if (REPL_POLICY == 0) begin
            victim = rr_reg[lk_idx];
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_reg[lk_idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[lk_idx][w]) victim = AGE_W'(w);
        end
    end

    assign upd_way = (state_reg == ST_MISS) ? victim : hit_way;
    assign upd_age = age_reg[lk_idx][upd_way];

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_next[w] = age_reg[lk_idx][w];
            if (AGE_W'(w) == upd_way)
                age_next[w] = '0;
            else if (age_reg[lk_idx][w] < upd_age)
                age_next[w] = age_reg[lk_idx][w] + 1'b1;
        end
    end

    assign hit_line  = data_mem[hit_way][lk_idx];
    assign hit_word  = hit_line[lk_woff * WORD_BITS +: WORD_BITS];
    assign fill_word = mem_req_rdata[lk_woff * WORD_BITS +: WORD_BITS];
    assign fill_en   = (state_reg == ST_MISS) && mem_req_ready;
    assign flush_busy = flush_pend_reg;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[victim][lk_idx] <= mem_req_rdata;
            tag_mem[victim][lk_idx]  <= lk_tag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            flush_pend_reg <= 1'b0;
            flush_set_reg  <= '0;
            proc_ready     <= 1'b0;
            proc_rdata     <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                rr_reg[s]    <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_reg[s][w] <= AGE_W'(w);
            end
        end else begin
            proc_ready <= 1'b0;
            if (flush) flush_pend_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    // The cycle showing proc_ready still carries the old request, so skip it.
                    if (flush_pend_reg) begin
                        state_reg     <= ST_FLUSH;
                        flush_set_reg <= '0;
                    end else if (proc_valid && !flush && !proc_ready) begin
                        if (hit_any) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= hit_word;
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
                            for (int w = 0; w < NUM_WAYS; w++) age_reg[lk_idx][w] <= age_next[w];
                        end else begin
                            state_reg     <= ST_MISS;
                            addr_reg      <= proc_addr;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {proc_addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        end
                    end
                end
                ST_MISS: begin
                    if (mem_req_ready) begin
                        mem_req_valid             <= 1'b0;
                        valid_reg[lk_idx][victim] <= 1'b1;
                        rr_reg[lk_idx]            <= rr_reg[lk_idx] + 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) age_reg[lk_idx][w] <= age_next[w];
                        if (proc_valid) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= fill_word;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    valid_reg[flush_set_reg] <= '0;
                    rr_reg[flush_set_reg]    <= '0;
                    for (int w = 0; w < NUM_WAYS; w++) age_reg[flush_set_reg][w] <= AGE_W'(w);
                    flush_set_reg <= flush_set_reg + 1'b1;
                    if (flush_set_reg == IDX_W'(NUM_SETS - 1)) begin
                        state_reg      <= ST_IDLE;
                        flush_pend_reg <= flush;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_nway_wide_lru.sv
// Randomized bench for icache_nway_wide_lru: a round-robin and an LRU instance,
// each checked against a timestamp-based set-associative reference model.
module tb_icache_nway_wide_lru;
    localparam int SETS     = 4;
    localparam int WAYS     = 2;
    localparam int BLOCKS   = 4;
    localparam int LINE_OFF = 4;
    localparam int IDX_BITS = 2;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    logic         clk = 1'b0;
    logic         rstn   [2];
    logic         pv     [2];
    logic         pr     [2];
    logic [31:0]  pa     [2];
    logic [31:0]  rdata  [2];
    logic         flush_i[2];
    logic         busy   [2];
    logic         mrv    [2];
    logic         mrr    [2];
    logic [31:0]  maddr  [2];
    logic [127:0] mrd    [2];
    logic [31:0]  hc     [2];
    logic [31:0]  mc     [2];

    always #5 clk = ~clk;

    // Instance 0 uses round-robin replacement, instance 1 uses LRU.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        icache_nway_wide_lru #(
            .CACHE_SIZE(128), .NUM_WAYS(2), .NUM_BLOCKS(4), .BLOCK_SIZE(4), .REPL_POLICY(gi)
        ) u_dut (
            .clk(clk), .resetn(rstn[gi]),
            .proc_valid(pv[gi]), .proc_ready(pr[gi]), .proc_addr(pa[gi]), .proc_rdata(rdata[gi]),
            .flush(flush_i[gi]), .flush_busy(busy[gi]),
            .mem_req_valid(mrv[gi]), .mem_req_ready(mrr[gi]), .mem_req_addr(maddr[gi]),
            .mem_req_rdata(mrd[gi]), .hit_count(hc[gi]), .miss_count(mc[gi])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-way tag/valid, last-use timestamps for LRU, a fill pointer for RR.
    logic [31:0] m_tag   [2][SETS][WAYS];
    bit          m_val   [2][SETS][WAYS];
    int          m_stamp [2][SETS][WAYS];
    int          m_ptr   [2][SETS];
    int          m_hit   [2];
    int          m_miss  [2];
    int          m_time = 0;

    function automatic logic [127:0] line_data(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < BLOCKS; k++)
            l[k*32 +: 32] = (la * 32'h9E37_79B1) ^ (32'h1111_1111 * (k + 1));
        if (la == 32'h100) l[63:32] = 32'hCAFE_0001;
        return l;
    endfunction

    task automatic model_flush(input int d);
        for (int s = 0; s < SETS; s++) begin
            m_ptr[d][s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_val[d][s][w]   = 1'b0;
                m_stamp[d][s][w] = -w;
            end
        end
    endtask

    task automatic model_reset(input int d);
        model_flush(d);
        m_hit[d]  = 0;
        m_miss[d] = 0;
    endtask

    function automatic int pick_victim(input int d, input int s);
        int v;
        for (int w = 0; w < WAYS; w++)
            if (!m_val[d][s][w]) return w;
        if (d == 0) return m_ptr[d][s];
        v = 0;
        for (int w = 1; w < WAYS; w++)
            if (m_stamp[d][s][w] < m_stamp[d][s][v]) v = w;
        return v;
    endfunction

    task automatic fetch(input int d, input logic [31:0] addr, input bit drop,
                         input bit flush_mid, output bit was_hit);
        int s, hw, v, wo, n;
        logic [31:0] tg, la, ew;
        logic [127:0] line;
        s    = int'((addr >> LINE_OFF) % SETS);
        tg   = addr >> (LINE_OFF + IDX_BITS);
        la   = addr & LINE_MASK;
        line = line_data(la);
        wo   = int'((addr >> 2) % BLOCKS);
        ew   = line[wo*32 +: 32];
        hw   = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_val[d][s][w] && m_tag[d][s][w] == tg) hw = w;

        @(negedge clk);
        pv[d] = 1'b1;
        pa[d] = addr;
        @(negedge clk);
        was_hit = pr[d];
        if (hw >= 0) begin
            check("hit_ready", pr[d], 1'b1);
            check("hit_data", rdata[d], ew);
            check("hit_no_mem", mrv[d], 1'b0);
            m_hit[d]++;
            m_stamp[d][s][hw] = ++m_time;
        end else begin
            check("miss_req", mrv[d], 1'b1);
            check("miss_addr", maddr[d], la);
            check("miss_no_ready", pr[d], 1'b0);
            m_miss[d]++;
            if (flush_mid) begin
                flush_i[d] = 1'b1;
                @(negedge clk);
                flush_i[d] = 1'b0;
                check("flush_busy_in_miss", busy[d], 1'b1);
                check("miss_hold_on_flush", mrv[d], 1'b1);
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("req_hold", mrv[d], 1'b1);
                check("req_addr_hold", maddr[d], la);
            end
            if (drop) pv[d] = 1'b0;
            mrr[d] = 1'b1;
            mrd[d] = line;
            @(negedge clk);
            mrr[d] = 1'b0;
            mrd[d] = {$urandom, $urandom, $urandom, $urandom};
            check("fill_ready", pr[d], !drop);
            if (!drop) check("fill_data", rdata[d], ew);
            check("fill_req_drop", mrv[d], 1'b0);
            v = pick_victim(d, s);
            m_val[d][s][v]   = 1'b1;
            m_tag[d][s][v]   = tg;
            m_stamp[d][s][v] = ++m_time;
            m_ptr[d][s]      = (m_ptr[d][s] + 1) % WAYS;
            if (flush_mid) begin
                pv[d] = 1'b0;
                n = 0;
                while (busy[d] && n < 20) begin
                    @(negedge clk);
                    n++;
                    check("flush_no_ready", pr[d], 1'b0);
                end
                check("flush_after_fill_done", busy[d], 1'b0);
                model_flush(d);
            end
        end
        pv[d] = 1'b0;
        check("hit_count", hc[d], m_hit[d]);
        check("miss_count", mc[d], m_miss[d]);
    endtask

    task automatic do_flush(input int d, input bit with_pv, input logic [31:0] addr);
        int n;
        @(negedge clk);
        flush_i[d] = 1'b1;
        if (with_pv) begin
            pv[d] = 1'b1;
            pa[d] = addr;
        end
        @(negedge clk);
        flush_i[d] = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy[d]; i++) begin
            n++;
            check("flush_no_ready", pr[d], 1'b0);
            check("flush_no_mem", mrv[d], 1'b0);
            @(negedge clk);
        end
        pv[d] = 1'b0;
        check("flush_busy_len", n, 1 + SETS);
        model_flush(d);
        check("flush_keeps_hits", hc[d], m_hit[d]);
        check("flush_keeps_misses", mc[d], m_miss[d]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int r;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; pv[d] = 1'b0; pa[d] = '0; flush_i[d] = 1'b0;
            mrr[d] = 1'b0; mrd[d] = '0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", pr[d], 1'b0);
            check("rst_mem_valid", mrv[d], 1'b0);
            check("rst_flush_busy", busy[d], 1'b0);
            check("rst_hits", hc[d], 32'd0);
            check("rst_misses", mc[d], 32'd0);
            rstn[d] = 1'b1;
        end

        // Cold miss then same-line hit on the LRU instance.
        fetch(1, 32'h104, 1'b0, 1'b0, h);
        check("cold_is_miss", h, 1'b0);
        check("cold_word", rdata[1], 32'hCAFE_0001);
        fetch(1, 32'h108, 1'b0, 1'b0, h);
        check("warm_is_hit", h, 1'b1);
        check("warm_hits", hc[1], 32'd1);
        check("warm_misses", mc[1], 32'd1);

        // Replacement policy: the LRU keeps 0x000, round-robin evicts it.
        for (int d = 0; d < 2; d++) begin
            do_flush(d, 1'b0, 32'h0);
            fetch(d, 32'h000, 1'b0, 1'b0, h);
            fetch(d, 32'h040, 1'b0, 1'b0, h);
            fetch(d, 32'h000, 1'b0, 1'b0, h);
            fetch(d, 32'h080, 1'b0, 1'b0, h);
            fetch(d, 32'h000, 1'b0, 1'b0, h);
            check(d == 1 ? "lru_keeps_recent" : "rr_evicts_first", h, d == 1);
        end

        // Flush after three fills, with a request held during the flush.
        do_flush(1, 1'b0, 32'h0);
        fetch(1, 32'h000, 1'b0, 1'b0, h);
        fetch(1, 32'h010, 1'b0, 1'b0, h);
        fetch(1, 32'h020, 1'b0, 1'b0, h);
        do_flush(1, 1'b1, 32'h000);
        fetch(1, 32'h000, 1'b0, 1'b0, h);
        check("post_flush_miss", h, 1'b0);

        // Flush raised while a refill is outstanding.
        fetch(1, 32'h300, 1'b0, 1'b1, h);
        fetch(1, 32'h300, 1'b0, 1'b0, h);
        check("flush_in_miss_invalid", h, 1'b0);

        // Request dropped mid-refill, then re-requested.
        fetch(1, 32'h2A8, 1'b1, 1'b0, h);
        fetch(1, 32'h2A8, 1'b0, 1'b0, h);
        check("drop_rehit", h, 1'b1);

        // Asynchronous reset during a refill.
        @(negedge clk);
        pv[1] = 1'b1;
        pa[1] = 32'h1C4;
        @(negedge clk);
        check("pre_reset_req", mrv[1], 1'b1);
        #2 rstn[1] = 1'b0;
        #1;
        check("async_rst_mem_valid", mrv[1], 1'b0);
        check("async_rst_ready", pr[1], 1'b0);
        check("async_rst_hits", hc[1], 32'd0);
        check("async_rst_misses", mc[1], 32'd0);
        pv[1] = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b1;
        model_reset(1);
        fetch(1, 32'h1C4, 1'b0, 1'b0, h);
        check("post_reset_miss", h, 1'b0);

        // Random traffic over a small line pool so both hits and evictions occur.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                r = $urandom_range(0, 99);
                a = 32'h1000 + ($urandom_range(0, 23) << 4) + ($urandom_range(0, 3) << 2)
                    + $urandom_range(0, 3);
                if (r < 3)
                    do_flush(d, r[0], a);
                else
                    fetch(d, a, r < 12, r >= 12 && r < 15, h);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
